button_debouncer: RTL and testbench

Input-side counterpart to the LED output path. It conditions the low-active push button into clean, single-clock-cycle events for downstream counters and LED logic in the same clock domain. The block performs a 2-FF synchronization stage, then a consecutive-sample debounce. It then produces press, release, long-press and auto-repeat ticks, plus a debounced level.

---
 rtl/button_debouncer.sv | 154 +++++++++++++++
 tb/tb_button_debouncer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-stage synchronizer, consecutive-sample
// debounce, and a press/hold state machine. It emits single-cycle press,
// release, long-press and auto-repeat ticks plus a debounced level.
// Every output is a register. No combinational path runs from btnx to any output.
module button_debouncer #(
  parameter int DebounceCycles  = 24000,
  parameter int LongPressCycles = 12000000,
  parameter int RepeatCycles    = 2400000
) (
  input  logic clk,
  input  logic async_rstx,
  input  logic btnx,
  output logic pressed,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick
);

  // One width serves both counters; it is sized from the largest period.
  localparam int MaxDL     = (DebounceCycles > LongPressCycles) ? DebounceCycles : LongPressCycles;
  localparam int MaxCycles = (MaxDL > RepeatCycles) ? MaxDL : RepeatCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] DebLast  = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LongPressCycles - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'((RepeatCycles > 0) ? RepeatCycles - 1 : 0);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } state_e;

  logic            sync1_q, sync2_q;
  logic            sample;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic            deb_q, deb_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic            pressed_d, press_tick_d, release_tick_d, long_tick_d, repeat_tick_d;

  // Bring the raw button into the clk domain. Both stages reset to released (1).
  always_ff @(posedge clk or negedge async_rstx) begin
    if (!async_rstx) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btnx;
      sync2_q <= sync1_q;
    end
  end

  // Active-high pushed sample.
  assign sample = ~sync2_q;

  // Debounce: count consecutive disagreeing samples and flip after DebounceCycles.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_d     = deb_q;
    if (sample == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebLast) begin
      deb_d     = ~deb_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CntW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge async_rstx) begin
    if (!async_rstx) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  // Hold FSM: next state, hold counter and tick decisions. Release wins over terminal counts.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    press_tick_d   = 1'b0;
    release_tick_d = 1'b0;
    long_tick_d    = 1'b0;
    repeat_tick_d  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (deb_q) begin
          state_d      = ST_HELD;
          hold_cnt_d   = '0;
          press_tick_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!deb_q) begin
          state_d        = ST_RELEASED;
          hold_cnt_d     = '0;
          release_tick_d = 1'b1;
        end else if (hold_cnt_q == LongLast) begin
          state_d     = ST_LONG;
          hold_cnt_d  = '0;
          long_tick_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      ST_LONG: begin
        if (!deb_q) begin
          state_d        = ST_RELEASED;
          hold_cnt_d     = '0;
          release_tick_d = 1'b1;
        end else if (RepeatCycles > 0) begin
          if (hold_cnt_q == RepLast) begin
            hold_cnt_d    = '0;
            repeat_tick_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d    = ST_RELEASED;
        hold_cnt_d = '0;
      end
    endcase
    pressed_d = (state_d != ST_RELEASED);
  end

  // FSM state, hold counter and registered outputs.
  always_ff @(posedge clk or negedge async_rstx) begin
    if (!async_rstx) begin
      state_q      <= ST_RELEASED;
      hold_cnt_q   <= '0;
      pressed      <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pressed      <= pressed_d;
      press_tick   <= press_tick_d;
      release_tick <= release_tick_d;
      long_tick    <= long_tick_d;
      repeat_tick  <= repeat_tick_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer. Two instances share one stimulus: one with
// auto-repeat and one with repeat disabled. Both are checked every edge
// against a history-based model of the debounce and hold timing rules.
module tb_button_debouncer;

  localparam int D    = 4;
  localparam int L    = 20;
  localparam int R    = 8;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic async_rstx;
  logic btnx;
  logic pressed_a, press_a, rel_a, long_a, rep_a;
  logic pressed_b, press_b, rel_b, long_b, rep_b;

  always #5 clk = ~clk;

  button_debouncer #(.DebounceCycles(D), .LongPressCycles(L), .RepeatCycles(R)) dut_a (
    .clk(clk), .async_rstx(async_rstx), .btnx(btnx),
    .pressed(pressed_a), .press_tick(press_a), .release_tick(rel_a),
    .long_tick(long_a), .repeat_tick(rep_a)
  );

  button_debouncer #(.DebounceCycles(D), .LongPressCycles(L), .RepeatCycles(0)) dut_b (
    .clk(clk), .async_rstx(async_rstx), .btnx(btnx),
    .pressed(pressed_b), .press_tick(press_b), .release_tick(rel_b),
    .long_tick(long_b), .repeat_tick(rep_b)
  );

  int total = 0;
  int bad   = 0;

  // Model state: raw button per edge since reset and the debounced level per edge.
  logic b_hist   [0:MAXE-1];
  logic deb_hist [0:MAXE-1];
  int   n;            // edge index since reset release
  int   press_edge;   // edge of the current press_tick, -1 when not held

  // Directed-observation bookkeeping.
  int first_press_n, last_rel_n;
  int cnt_press_a, cnt_rel_a, cnt_long_a, cnt_rep_a, cnt_long_b, cnt_rep_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic s_use(input int k);
    // The sample seen at edge k is the button two edges earlier, inverted; before reset release it is released.
    return (k >= 2) ? ~b_hist[k-2] : 1'b0;
  endfunction

  function automatic logic deb_at(input int k);
    return (k >= 0) ? deb_hist[k] : 1'b0;
  endfunction

  task automatic model_reset();
    n          = 0;
    press_edge = -1;
  endtask

  task automatic clear_counts();
    cnt_press_a = 0; cnt_rel_a = 0; cnt_long_a = 0;
    cnt_rep_a   = 0; cnt_long_b = 0; cnt_rep_b  = 0;
  endtask

  // One clock edge: drive btnx, advance the model, and compare both DUTs 1 ns after the edge.
  task automatic tick(input logic b);
    logic prev, all_diff, d1, d2;
    logic e_press, e_rel, e_long, e_rep_a;
    int   age;
    btnx = b;
    @(posedge clk);
    if (n >= MAXE) begin
      $display("FAIL model_overflow observed=%0d expected<%0d", n, MAXE);
      $fatal(1, "model history exhausted");
    end
    b_hist[n] = b;
    prev = deb_at(n - 1);
    all_diff = 1'b1;
    for (int i = n - D + 1; i <= n; i++)
      if (s_use(i) == prev) all_diff = 1'b0;
    deb_hist[n] = all_diff ? ~prev : prev;
    d1 = deb_at(n - 1);
    d2 = deb_at(n - 2);
    e_press = d1 & ~d2;
    e_rel   = ~d1 & d2;
    if (e_press) press_edge = n;
    if (e_rel)   press_edge = -1;
    age     = n - press_edge;
    e_long  = (press_edge >= 0) && (age == L);
    e_rep_a = (press_edge >= 0) && (age > L) && (((age - L) % R) == 0);
    #1;
    check("outs_a", {27'd0, pressed_a, press_a, rel_a, long_a, rep_a},
          {27'd0, d1, e_press, e_rel, e_long, e_rep_a});
    check("outs_b", {27'd0, pressed_b, press_b, rel_b, long_b, rep_b},
          {27'd0, d1, e_press, e_rel, e_long, 1'b0});
    check("onehot_a", {31'd0, ($countones({press_a, rel_a, long_a, rep_a}) <= 1)}, 32'd1);
    if (press_a) begin
      cnt_press_a++;
      if (first_press_n < 0) first_press_n = n;
    end
    if (rel_a) begin
      cnt_rel_a++;
      last_rel_n = n;
    end
    if (long_a) cnt_long_a++;
    if (rep_a)  cnt_rep_a++;
    if (long_b) cnt_long_b++;
    if (rep_b)  cnt_rep_b++;
    n++;
    @(negedge clk);
  endtask

  task automatic run(input logic lvl, input int len);
    for (int i = 0; i < len; i++) tick(lvl);
    $display("run btnx=%0b len=%0d edge=%0d pressed=%0b", lvl, len, n, pressed_a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, {27'd0, pressed_a, press_a, rel_a, long_a, rep_a}, 32'd0);
    check({tag, "_b"}, {27'd0, pressed_b, press_b, rel_b, long_b, rep_b}, 32'd0);
  endtask

  initial begin
    int rise_n;
    logic lvl;
    int len;
    btnx       = 1'b0;
    async_rstx = 1'b0;
    model_reset();
    first_press_n = -1;
    last_rel_n    = -1;
    clear_counts();

    // Reset held with the button pushed: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero("in_reset");
    end
    @(negedge clk);
    async_rstx = 1'b1;
    run(1'b0, 12);
    check("first_press_edge", first_press_n, 6);
    run(1'b1, 12);

    // Bounce shorter than the debounce window never registers.
    clear_counts();
    run(1'b0, 3); run(1'b1, 1); run(1'b0, 3); run(1'b1, 12);
    check("bounce_press_cnt", cnt_press_a, 0);
    run(1'b0, 8);
    check("steady_press_cnt", cnt_press_a, 1);
    run(1'b1, 12);

    // Short press: release tick exactly 6 edges after the button goes high.
    clear_counts();
    run(1'b0, 10);
    rise_n = n;
    run(1'b1, 12);
    check("short_rel_latency", last_rel_n - rise_n, 6);
    check("short_long_cnt", cnt_long_a, 0);

    // 60-cycle hold: one long, repeats at +8..+32; the +40 repeat coincides with release and is dropped.
    clear_counts();
    run(1'b0, 60);
    run(1'b1, 15);
    check("hold_long_a", cnt_long_a, 1);
    check("hold_rep_a", cnt_rep_a, 4);
    check("hold_long_b", cnt_long_b, 1);
    check("hold_rep_b", cnt_rep_b, 0);
    check("hold_rel_a", cnt_rel_a, 1);

    // Random bouncy traffic with occasional long holds.
    lvl = 1'b0;
    for (int k = 0; k < 30; k++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 12);
      run(lvl, len);
      lvl = ~lvl;
    end
    run(1'b1, 12);

    // Asynchronous reset in the middle of LONG: outputs clear at once, no release tick.
    run(1'b0, 35);
    check("long_before_rst", {31'd0, pressed_a}, 32'd1);
    @(posedge clk); #3;
    async_rstx = 1'b0;
    #1;
    check_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    model_reset();
    first_press_n = -1;
    async_rstx = 1'b1;
    run(1'b0, 12);
    check("repress_edge", first_press_n, 6);
    run(1'b1, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
